// File: rtl/leaf_loopback_n_if.sv
// Switch-side leaf packet bus: inbound packet, outbound packet and resend request.
// The leaf uses the slave modport; the switch (or bench) drives through master.
interface leaf_loopback_n_if #(
  parameter int PACKET_BITS = 49
);
  logic [PACKET_BITS-1:0] din_leaf_bft2interface;
  logic [PACKET_BITS-1:0] dout_leaf_interface2bft;
  logic                   resend;

  modport master (
    output din_leaf_bft2interface,
    output resend,
    input  dout_leaf_interface2bft
  );

  modport slave (
    input  din_leaf_bft2interface,
    input  resend,
    output dout_leaf_interface2bft
  );
endinterface

// File: rtl/leaf_loopback_n.sv
// BFT echo leaf: buffers {port,payload} of packets addressed to LEAF_ID and returns them to
// RET_LEAF with payload+1 and a per-port sequence number. LEAF_PKT_STATS_EN adds drop/error counters.
module leaf_loopback_n #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int LEAF_ID       = 5,
  parameter int NUM_PORTS     = 2,
  parameter int FIFO_DEPTH    = 16,
  parameter int OUT_GAP       = 1,
  parameter int RET_LEAF      = 0,
  parameter int RET_PORT_BASE = 8
) (
  input  logic             clk,
  input  logic             reset,
  leaf_loopback_n_if.slave bus
`ifdef LEAF_PKT_STATS_EN
  ,
  output logic [15:0]      stat_drop_cnt,
  output logic [15:0]      stat_err_cnt
`endif
);
  localparam int ADDR_LO    = PAYLOAD_BITS;
  localparam int PORT_LO    = ADDR_LO + NUM_ADDR_BITS;
  localparam int LEAF_LO    = PORT_LO + NUM_PORT_BITS;
  localparam int VALID_BIT  = LEAF_LO + NUM_LEAF_BITS;
  localparam int ENTRY_BITS = NUM_PORT_BITS + PAYLOAD_BITS;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CW         = AW + 1;
  localparam int PW1        = NUM_PORT_BITS + 1;

  localparam logic [NUM_LEAF_BITS-1:0] LEAF_ID_V   = NUM_LEAF_BITS'(LEAF_ID);
  localparam logic [NUM_LEAF_BITS-1:0] RET_LEAF_V  = NUM_LEAF_BITS'(RET_LEAF);
  localparam logic [NUM_PORT_BITS-1:0] RET_BASE_V  = NUM_PORT_BITS'(RET_PORT_BASE);
  localparam logic [PW1-1:0]           NUM_PORTS_V = PW1'(NUM_PORTS);
  localparam logic [CW-1:0]            FULL_V      = CW'(FIFO_DEPTH);
  localparam logic [3:0]               GAP_LOAD    = 4'(OUT_GAP - 1);

  logic [ENTRY_BITS-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [NUM_ADDR_BITS-1:0] seq_q [NUM_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_d [NUM_PORTS];
  logic [3:0]               gap_q, gap_d;
  logic                     emitted_q, emitted_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d, last_q, last_d;

  logic                     in_valid, addr_ok, fifo_full, emit_ok;
  logic                     do_resend, do_pop, do_push;
  logic [NUM_LEAF_BITS-1:0] in_leaf;
  logic [NUM_PORT_BITS-1:0] in_port, pop_port, ret_port;
  logic [PAYLOAD_BITS-1:0]  in_payload, pop_payload;
  logic [NUM_ADDR_BITS-1:0] unused_in_addr, seq_sel;
  logic [ENTRY_BITS-1:0]    in_entry, rd_entry;
  logic [PACKET_BITS-1:0]   ret_pkt;

  // Ingress decode and the emit/pop/push decisions for this edge.
  always_comb begin
    in_valid       = bus.din_leaf_bft2interface[VALID_BIT];
    in_leaf        = bus.din_leaf_bft2interface[LEAF_LO +: NUM_LEAF_BITS];
    in_port        = bus.din_leaf_bft2interface[PORT_LO +: NUM_PORT_BITS];
    unused_in_addr = bus.din_leaf_bft2interface[ADDR_LO +: NUM_ADDR_BITS];
    in_payload     = bus.din_leaf_bft2interface[PAYLOAD_BITS-1:0];
    in_entry       = {in_port, in_payload};
    addr_ok        = (in_leaf == LEAF_ID_V) && ({1'b0, in_port} < NUM_PORTS_V);
    fifo_full      = (count_q == FULL_V);
    emit_ok        = (gap_q == 4'd0);
    // Resend outranks the FIFO, but only once something has actually been emitted.
    do_resend      = emit_ok && bus.resend && emitted_q;
    do_pop         = emit_ok && !do_resend && (count_q != {CW{1'b0}});
    do_push        = in_valid && addr_ok && (!fifo_full || do_pop);
  end

  // Build the returned packet from the FIFO head and its port's sequence number.
  always_comb begin
    rd_entry    = mem_q[rd_ptr_q];
    pop_port    = rd_entry[PAYLOAD_BITS +: NUM_PORT_BITS];
    pop_payload = rd_entry[PAYLOAD_BITS-1:0];
    ret_port    = RET_BASE_V + pop_port;
    seq_sel     = {NUM_ADDR_BITS{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pop_port == NUM_PORT_BITS'(i)) begin
        seq_sel = seq_q[i];
      end else begin
        seq_sel = seq_sel;
      end
    end
    ret_pkt                               = {PACKET_BITS{1'b0}};
    ret_pkt[VALID_BIT]                    = 1'b1;
    ret_pkt[LEAF_LO +: NUM_LEAF_BITS]     = RET_LEAF_V;
    ret_pkt[PORT_LO +: NUM_PORT_BITS]     = ret_port;
    ret_pkt[ADDR_LO +: NUM_ADDR_BITS]     = seq_sel;
    ret_pkt[PAYLOAD_BITS-1:0]             = pop_payload + PAYLOAD_BITS'(1);
  end

  // Next-state for FIFO pointers, sequence counters, gap timer and output register.
  always_comb begin
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    seq_d = seq_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (do_pop && (pop_port == NUM_PORT_BITS'(i))) begin
        seq_d[i] = seq_q[i] + NUM_ADDR_BITS'(1);
      end else begin
        seq_d[i] = seq_q[i];
      end
    end
    if (do_resend) begin
      dout_d = last_q;
    end else if (do_pop) begin
      dout_d = ret_pkt;
    end else begin
      dout_d = {PACKET_BITS{1'b0}};
    end
    if (do_pop) begin
      last_d = ret_pkt;
    end else begin
      last_d = last_q;
    end
    emitted_d = emitted_q | do_pop;
    if (do_resend || do_pop) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end else begin
      gap_d = gap_q;
    end
  end

  // Control state; reset empties the FIFO and clears dout immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      gap_q     <= 4'd0;
      emitted_q <= 1'b0;
      dout_q    <= {PACKET_BITS{1'b0}};
      last_q    <= {PACKET_BITS{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
        seq_q[i] <= {NUM_ADDR_BITS{1'b0}};
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      emitted_q <= emitted_d;
      dout_q    <= dout_d;
      last_q    <= last_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        seq_q[i] <= seq_d[i];
      end
    end
  end

  // FIFO storage; contents are meaningless outside the pointer window so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign bus.dout_leaf_interface2bft = dout_q;

`ifdef LEAF_PKT_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;
  logic        is_drop, is_err;

  // Saturating overflow/address-error counters.
  always_comb begin
    is_drop = in_valid && addr_ok && fifo_full && !do_pop;
    is_err  = in_valid && !addr_ok;
    if (is_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    if (is_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Counter registers, cleared by reset only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= 16'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign stat_drop_cnt = drop_cnt_q;
  assign stat_err_cnt  = err_cnt_q;
`endif
endmodule
